// File: rtl/display_scan_scheduler_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan scheduler.
package display_scan_scheduler_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned SUBSLOTS   = 8;
    localparam logic [7:0]  ANODE_OFF  = 8'hFF;

    typedef logic [2:0] digit_idx_t;

endpackage

// File: rtl/display_scan_scheduler_if.sv
// Control inputs and display outputs of the scan scheduler.
interface display_scan_scheduler_if;
    import display_scan_scheduler_pkg::*;

    logic                  en;
    logic [NUM_DIGITS-1:0] digit_mask;
    logic [2:0]            brightness;
    logic [NUM_DIGITS-1:0] anode;
    digit_idx_t            S;
    logic                  frame_done;

    modport master (
        output en, digit_mask, brightness,
        input  anode, S, frame_done
    );

    modport slave (
        input  en, digit_mask, brightness,
        output anode, S, frame_done
    );

endinterface

// File: rtl/display_scan_scheduler_refresh_tick_gen.sv
// Enable-gated prescaler emitting a one-cycle tick every TICK_DIV enabled clocks.
module refresh_tick_gen #(
    parameter int unsigned TICK_DIV = 12500
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned CntW = $clog2(TICK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= (cnt_q == CntMax) ? '0 : cnt_q + 1'b1;
        end
    end

    assign tick_o = en_i && (cnt_q == CntMax);

endmodule

// File: rtl/display_scan_scheduler.sv
// Digit scan sequencer: skips masked-off digits, PWM-dims within each slot, flags frame wrap.
module display_scan_scheduler
    import display_scan_scheduler_pkg::*;
#(
    parameter int unsigned TICK_DIV = 12500
) (
    input  logic                     clk,
    input  logic                     reset,
    display_scan_scheduler_if.slave  dsif
);

    // First enabled digit after cur, wrapping round to cur itself last.
    function automatic digit_idx_t next_digit(digit_idx_t cur, logic [NUM_DIGITS-1:0] mask);
        digit_idx_t res;
        digit_idx_t cand;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= NUM_DIGITS; k++) begin
            cand = cur + digit_idx_t'(k);
            if (!found && mask[cand]) begin
                res   = cand;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    logic                  tick;
    logic                  boundary;
    digit_idx_t            s_next;
    logic [NUM_DIGITS-1:0] anode_d;

    logic [2:0]            sub_q;
    digit_idx_t            s_q;
    logic [NUM_DIGITS-1:0] mask_q;
    logic [2:0]            bright_q;
    logic [NUM_DIGITS-1:0] anode_q;
    logic                  frame_done_q;

    refresh_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .en_i   (dsif.en),
        .tick_o (tick)
    );

    always_comb begin
        boundary = tick && (sub_q == 3'd7);
        s_next   = next_digit(s_q, dsif.digit_mask);
        anode_d  = ANODE_OFF;
        if (dsif.en && mask_q[s_q] && (sub_q <= bright_q)) begin
            anode_d = ~(8'b1 << s_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sub_q        <= '0;
            s_q          <= '0;
            mask_q       <= '0;
            bright_q     <= '0;
            anode_q      <= ANODE_OFF;
            frame_done_q <= 1'b0;
        end else begin
            anode_q      <= anode_d;
            frame_done_q <= 1'b0;
            if (tick) begin
                sub_q <= sub_q + 3'd1;
            end
            if (boundary) begin
                mask_q       <= dsif.digit_mask;
                bright_q     <= dsif.brightness;
                s_q          <= s_next;
                // An empty mask holds S, so it must not count as a wrap.
                frame_done_q <= (dsif.digit_mask != '0) && (s_next <= s_q);
            end
        end
    end

    assign dsif.anode      = anode_q;
    assign dsif.S          = s_q;
    assign dsif.frame_done = frame_done_q;

endmodule

// File: doc/display_scan_scheduler.md
Name: display_scan_scheduler

Overview:
- Sequences the shared 8-digit multiplexed 7-segment display.
- Drives the active-low anode lines and the 3-bit digit-select S that feeds the segment data mux.
- Adds three features over a fixed scan:
  - programmable refresh rate;
  - per-digit enable mask, so disabled digits are skipped rather than blanked in place;
  - 8-level brightness by PWM within each digit slot.
- Emits a frame_done strobe for upstream display-data updates.

Parameters:
- TICK_DIV, 12500: clk cycles per sub-slot tick. One digit slot is 8 ticks.
- NUM_DIGITS, 8: number of anodes. Fixed at 8; exists for readability only.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  scan enable; 0 blanks the display and freezes the scan
- digit_mask  in  8  1 = digit participates in scan; bit i maps to anode[i]
- brightness  in  3  on-time per slot = (brightness+1)/8
- anode  out  8  active-low digit enables, registered
- S  out  3  index of the digit currently owning the slot, registered
- frame_done  out  1  one-cycle pulse when the scan wraps

Behaviour:
- Reset (synchronous, active-high), applied on the next clk edge:
  - prescaler = 0, sub = 0, S = 0;
  - mask_q = 8'h00, bright_q = 0;
  - anode = 8'hFF, frame_done = 0.
  - Reset mid-slot aborts the slot immediately, with no partial-state carry-over.
- Prescaler:
  - Counts 0..TICK_DIV-1 while en = 1.
  - tick = 1 on the cycle when count == TICK_DIV-1; the count then wraps to 0.
  - Holds its value while en = 0.
- Sub-slot counter:
  - sub (3 bits) increments on each tick and wraps 7 -> 0.
  - Slot boundary = tick && sub == 7.
- At each slot boundary:
  - mask_q <= digit_mask and bright_q <= brightness. Mid-slot input changes have no effect until the next boundary.
  - Next S: the first set bit of the newly sampled mask, searched in order S+1, S+2, ..., S+7, S (mod 8). The current digit is chosen only if it is the sole enabled digit.
  - If the sampled mask == 0, S holds.
  - frame_done = 1 for exactly one cycle (registered, coincident with the S update) when the new S <= the old S and the mask != 0.
    - With a single enabled digit, frame_done pulses every slot.
    - With mask == 0, frame_done never pulses.
- anode, registered; one cycle of latency from S/sub/mask_q/bright_q:
  - anode = ~(8'b1 << S) when en && mask_q[S] && (sub <= bright_q);
  - otherwise anode = 8'hFF.
  - Never more than one anode bit is low.
- en = 0:
  - anode = 8'hFF on the next cycle;
  - prescaler, sub, S, mask_q and bright_q hold;
  - frame_done = 0.
  - On en = 1 the scan resumes from the held state.
- After reset, the first slot is dark because mask_q = 0. The first boundary loads the mask and selects the lowest enabled digit above 0, or 0 if digit 0 is the only enabled digit.
- Arithmetic:
  - S+k wraps mod 8 naturally in 3 bits.
  - Prescaler width = $clog2(TICK_DIV).
  - TICK_DIV >= 2 is required.

Decomposition:
- Shared package holds:
  - NUM_DIGITS = 8;
  - ANODE_OFF = 8'hFF;
  - SUBSLOTS = 8;
  - a 3-bit digit-index typedef.
- Sub-module refresh_tick_gen: a parameterised prescaler with en, producing the single-cycle tick. It is reusable by other display and debounce logic.
- Next-enabled-digit search: a combinational function inside the scheduler.

Test Plan (TICK_DIV = 4, so slot = 32 clks):
- Reset asserted for 3 clks with en = 1 and digit_mask = FF -> anode = FF, S = 0, frame_done = 0 throughout. The first 32 clks after release are dark; then S = 1.
- digit_mask = FF, brightness = 7, en = 1 -> S steps 1,2,...,7,0,1, holding each value for 32 clks. anode = ~(1<<S) continuously. frame_done is a single pulse at the 7 -> 0 transition, every 256 clks.
- brightness = 1, digit_mask = FF -> in each slot, anode is low for 8 clks (sub 0-1) and FF for 24 clks. Changing brightness to 5 mid-slot takes effect only at the next slot.
- digit_mask = 8'b0010_0100 -> S alternates 2, 5, 2, 5, and digits 0, 1, 3, 4, 6, 7 are never low. frame_done pulses on each 5 -> 2.
- digit_mask changed to 00 -> after the next boundary anode = FF, S holds, and frame_done stays 0. Restoring 8'h01 gives S = 0 and a frame_done pulse every 32 clks.
- en dropped for 10 clks mid-slot -> anode = FF on the following clk, and S and counters freeze. On en = 1 the slot completes its remaining clks, so total slot length = 32 enabled clks. Reset asserted mid-slot gives S = 0 and anode = FF on the next edge.
